// File: rtl/arb_mux_n_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_n_rtl
//  Description : N-channel, W-bit arbitrating mux with a one-entry registered
//                output buffer. Each cycle it grants one valid input channel,
//                using either round-robin or fixed priority (channel 0
//                highest). The granted channel's data is captured into the
//                output register. Both sides use val/rdy handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux_n_rtl #(
    parameter int p_nch   = 4,
    parameter int p_nbits = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [p_nch-1:0]           in_val,
    output logic [p_nch-1:0]           in_rdy,
    input  logic [p_nch*p_nbits-1:0]   in_data,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [p_nbits-1:0]         out_data,
    output logic [$clog2(p_nch)-1:0]   out_sel
);

    localparam int SEL_W = $clog2(p_nch);

    // Output register and round-robin pointer
    logic               out_val_q,  out_val_d;
    logic [p_nbits-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q,  out_sel_d;
    logic [SEL_W-1:0]   ptr_q,      ptr_d;

    // Grant result and handshake qualifiers
    logic               gnt_vld;
    logic [SEL_W-1:0]   gnt_idx;
    logic               space;
    logic               xfer_in;
    logic               xfer_out;

    // The buffer can take a new item if it is empty or being drained now.
    assign space    = !out_val_q || out_rdy;
    assign xfer_in  = space && gnt_vld;
    assign xfer_out = out_val_q && out_rdy;

    // Grant search: walk the channels in priority order and take the first
    // valid one. Round-robin starts at ptr and wraps; fixed starts at 0.
    always_comb begin
        int ch;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        ch      = 0;
        for (int k = 0; k < p_nch; k++) begin
            ch = mode ? k : ((int'(ptr_q) + k) % p_nch);
            if (!gnt_vld && in_val[ch]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(ch);
            end
        end
    end

    // Ready goes only to the granted channel, and never while in reset so
    // an upstream source cannot believe an item was accepted and then lost.
    always_comb begin
        in_rdy = '0;
        if (!rst && xfer_in) begin
            in_rdy[gnt_idx] = 1'b1;
        end
    end

    // Next-state for the buffer and pointer. A capture takes precedence over
    // a drain, which gives back-to-back throughput when out_rdy stays high.
    // Only the granted slice of in_data is selected, so unknowns on other
    // channels never reach the register.
    always_comb begin
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;
        if (xfer_in) begin
            out_val_d  = 1'b1;
            out_data_d = in_data[int'(gnt_idx)*p_nbits +: p_nbits];
            out_sel_d  = gnt_idx;
            if (!mode) begin
                ptr_d = (gnt_idx == SEL_W'(p_nch - 1)) ? '0
                                                       : gnt_idx + SEL_W'(1);
            end
        end else if (xfer_out) begin
            out_val_d = 1'b0;
        end
    end

    // State update; reset discards any held item regardless of handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= '0;
        end else begin
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_val  = out_val_q;
    assign out_data = out_data_q;
    assign out_sel  = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_n_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux_n_rtl
//  Description : Self-checking bench for arb_mux_n_rtl (4 channels x 4 bits).
//                Directed vector table followed by randomized traffic checked
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux_n_rtl;

    localparam int N = 4;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [N-1:0]     in_val;
    logic [N-1:0]     in_rdy;
    logic [N*W-1:0]   in_data;
    logic             out_val;
    logic             out_rdy;
    logic [W-1:0]     out_data;
    logic [1:0]       out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    arb_mux_n_rtl #(.p_nch(N), .p_nbits(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_sel  (out_sel)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int             m_ptr;
    bit             m_oval;
    logic [W-1:0]   m_odata;
    int             m_osel;

    typedef struct {
        logic         r;
        logic         m;
        logic [N-1:0] v;
        logic [N*W-1:0] d;
        logic         ordy;
        logic [N-1:0] e_rdy;
        logic         e_oval;
        logic [W-1:0] e_odata;
        logic [1:0]   e_osel;
    } vec_t;

    vec_t tbl[26];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Grant by the arbitration rule: list channels in priority order and
    // return the first one that is valid, or -1.
    function automatic int model_grant(input logic m, input logic [N-1:0] v, input int ptr);
        int order[N];
        for (int k = 0; k < N; k++) order[k] = m ? k : (ptr + k) % N;
        for (int k = 0; k < N; k++) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    // One clock cycle: drive inputs, check in_rdy before the edge, advance the
    // model at the edge, check registered outputs at the following negedge.
    task automatic step(input logic r, input logic m, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input logic ordy,
                        output logic [N-1:0] a_rdy, output logic a_oval,
                        output logic [W-1:0] a_odata, output logic [1:0] a_osel);
        int g;
        bit sp;
        logic [N-1:0] e_rdy;
        rst = r; mode = m; in_val = v; in_data = d; out_rdy = ordy;
        g  = model_grant(m, v, m_ptr);
        sp = !m_oval || ordy;
        e_rdy = '0;
        if (!r && sp && g >= 0) e_rdy[g] = 1'b1;
        #1;
        a_rdy = in_rdy;
        check("model_in_rdy", 32'(in_rdy), 32'(e_rdy));
        @(posedge clk);
        if (r) begin
            m_oval = 0; m_odata = '0; m_osel = 0; m_ptr = 0;
        end else if (sp && g >= 0) begin
            m_oval  = 1;
            m_odata = d[g*W +: W];
            m_osel  = g;
            if (!m) m_ptr = (g + 1) % N;
        end else if (m_oval && ordy) begin
            m_oval = 0;
        end
        @(negedge clk);
        a_oval = out_val; a_odata = out_data; a_osel = out_sel;
        check("model_out_val",  32'(out_val),  32'(m_oval));
        check("model_out_data", 32'(out_data), 32'(m_odata));
        check("model_out_sel",  32'(out_sel),  32'(m_osel));
    endtask

    initial begin
        logic [N-1:0] a_rdy;
        logic         a_oval;
        logic [W-1:0] a_odata;
        logic [1:0]   a_osel;

        m_ptr = 0; m_oval = 0; m_odata = '0; m_osel = 0;
        rst = 1'b1; mode = 1'b0; in_val = '0; in_data = '0; out_rdy = 1'b0;

        //          r  m  val   data      ordy rdy  oval odata osel
        // reset with everything requesting
        tbl[0]  = '{1'b1, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0};
        // round-robin rotation 0,1,2,3,0
        tbl[2]  = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h4, 1'b1, 4'hC, 2'd2};
        tbl[5]  = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
        tbl[6]  = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0};
        // move ptr to 2, then sparse 3/1 requests: 3, 1, 3
        tbl[7]  = '{1'b0, 1'b0, 4'h2, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
        tbl[8]  = '{1'b0, 1'b0, 4'hA, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
        tbl[9]  = '{1'b0, 1'b0, 4'hA, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
        tbl[10] = '{1'b0, 1'b0, 4'hA, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
        // backpressure: capture ch2=5, stall 3 cycles, then release
        tbl[11] = '{1'b0, 1'b0, 4'h4, 16'hD5BA, 1'b1, 4'h4, 1'b1, 4'h5, 2'd2};
        tbl[12] = '{1'b0, 1'b0, 4'hF, 16'hD5BA, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2};
        tbl[13] = '{1'b0, 1'b0, 4'hF, 16'hD5BA, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2};
        tbl[14] = '{1'b0, 1'b0, 4'hF, 16'hD5BA, 1'b0, 4'h0, 1'b1, 4'h5, 2'd2};
        tbl[15] = '{1'b0, 1'b0, 4'hF, 16'hD5BA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
        // ptr to 3, fixed priority keeps ptr, round-robin resumes at 3
        tbl[16] = '{1'b0, 1'b0, 4'h4, 16'hD5BA, 1'b1, 4'h4, 1'b1, 4'h5, 2'd2};
        tbl[17] = '{1'b0, 1'b1, 4'hE, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
        tbl[18] = '{1'b0, 1'b1, 4'hE, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
        tbl[19] = '{1'b0, 1'b0, 4'hE, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3};
        // reset mid-stream with a stalled item
        tbl[20] = '{1'b0, 1'b0, 4'h2, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1};
        tbl[21] = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b0, 4'h0, 1'b1, 4'hB, 2'd1};
        tbl[22] = '{1'b1, 1'b0, 4'hF, 16'hDCBA, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0};
        tbl[23] = '{1'b0, 1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0};
        // drain with no new input, then idle with data held
        tbl[24] = '{1'b0, 1'b0, 4'h0, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'hA, 2'd0};
        tbl[25] = '{1'b0, 1'b0, 4'h0, 16'hDCBA, 1'b0, 4'h0, 1'b0, 4'hA, 2'd0};

        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].d, tbl[i].ordy,
                 a_rdy, a_oval, a_odata, a_osel);
            check($sformatf("vec%0d_in_rdy", i),   32'(a_rdy),   32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_out_val", i),  32'(a_oval),  32'(tbl[i].e_oval));
            check($sformatf("vec%0d_out_data", i), 32'(a_odata), 32'(tbl[i].e_odata));
            check($sformatf("vec%0d_out_sel", i),  32'(a_osel),  32'(tbl[i].e_osel));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 N'($urandom),
                 (N*W)'($urandom),
                 ($urandom_range(0, 3) != 0),
                 a_rdy, a_oval, a_odata, a_osel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
